// File: rtl/seq_detect_ctrl.sv
// Frame-based serial pattern detector: arms one frame through a cfg handshake,
// flags every overlapping match of a programmable pattern and counts them.
module seq_detect_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [PAT_W-1:0] cfg_pattern_i,
    input  logic [3:0]       cfg_len_i,
    input  logic [CNT_W-1:0] cfg_frame_i,
    input  logic             abort_i,
    input  logic             x_valid_i,
    input  logic             x_i,
    output logic             det_o,
    output logic [CNT_W-1:0] count_o,
    output logic             busy_o,
    output logic             done_o
);

    // state   | meaning
    // --------+-------------------------------------------------
    // ST_IDLE | waiting for configuration, cfg_ready_o high
    // ST_RUN  | scanning qualified bits of the armed frame
    // ST_DONE | one-cycle frame-complete pulse, then back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0]       LEN_MAX = 4'(PAT_W);
    localparam logic [3:0]       LEN_ONE = 4'd1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_next;

    logic [PAT_W-1:0]   r_pattern;
    // The oldest history bit is never compared, so only PAT_W-1 bits are kept.
    logic [PAT_W-2:0]   r_hist;
    logic [3:0]         r_len;
    logic [3:0]         r_seen;
    logic [CNT_W-1:0]   r_frame_rem;
    logic [CNT_W-1:0]   r_count;
    logic               r_det;

    logic [PAT_W-1:0]   w_hist_next;
    logic [PAT_W-1:0]   w_mask;
    logic [3:0]         w_seen_next;
    logic [3:0]         w_len_clamped;
    logic               w_accept;
    logic               w_sample;
    logic               w_last;
    logic               w_match;

    assign w_accept    = (r_state == ST_IDLE) && cfg_valid_i;
    assign w_sample    = (r_state == ST_RUN) && x_valid_i && !abort_i;
    assign w_last      = (r_frame_rem == '0);
    assign w_hist_next = {r_hist, x_i};
    assign w_seen_next = (r_seen == LEN_MAX) ? r_seen : (r_seen + LEN_ONE);

    always_comb begin
        w_len_clamped = cfg_len_i;
        if (cfg_len_i == 4'd0) begin
            w_len_clamped = LEN_ONE;
        end else if (cfg_len_i > LEN_MAX) begin
            w_len_clamped = LEN_MAX;
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_match = (w_seen_next >= r_len) &&
                     (((w_hist_next ^ r_pattern) & w_mask) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cfg_ready_o  = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_o = 1'b1;
                // Abort takes priority over a last bit sampled in the same cycle.
                if (abort_i) begin
                    w_state_next = ST_IDLE;
                end else if (x_valid_i && w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Frame length is tracked as a down-counter; the last bit is the one
    // sampled while the remaining count is zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern   <= '0;
            r_hist      <= '0;
            r_len       <= LEN_ONE;
            r_seen      <= '0;
            r_frame_rem <= '0;
            r_count     <= '0;
            r_det       <= 1'b0;
        end else begin
            r_det <= 1'b0;
            if (w_accept) begin
                r_pattern   <= cfg_pattern_i;
                r_len       <= w_len_clamped;
                r_frame_rem <= cfg_frame_i;
                r_hist      <= '0;
                r_seen      <= '0;
                r_count     <= '0;
            end else if (w_sample) begin
                r_hist <= w_hist_next[PAT_W-2:0];
                r_seen <= w_seen_next;
                if (!w_last) begin
                    r_frame_rem <= r_frame_rem - CNT_ONE;
                end
                if (w_match) begin
                    r_det <= 1'b1;
                    if (r_count != '1) begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
            end
        end
    end

    assign det_o   = r_det;
    assign count_o = r_count;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed frames plus randomized
// frames against a bit-list reference model.
module tb_seq_detect_ctrl;

    logic       clk;
    logic       reset;
    logic       cfg_valid_i;
    logic       cfg_ready_o;
    logic [7:0] cfg_pattern_i;
    logic [3:0] cfg_len_i;
    logic [7:0] cfg_frame_i;
    logic       abort_i;
    logic       x_valid_i;
    logic       x_i;
    logic       det_o;
    logic [7:0] count_o;
    logic       busy_o;
    logic       done_o;

    int errors = 0;
    int checks = 0;
    bit stim[$];
    int det_idx[$];
    int last_cnt;

    seq_detect_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_pattern_i(cfg_pattern_i),
        .cfg_len_i    (cfg_len_i),
        .cfg_frame_i  (cfg_frame_i),
        .abort_i      (abort_i),
        .x_valid_i    (x_valid_i),
        .x_i          (x_i),
        .det_o        (det_o),
        .count_o      (count_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_stim_str(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i] == 8'h31);
    endtask

    task automatic set_stim_const(input int n, input bit v);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(v);
    endtask

    task automatic set_stim_rand(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(1'($urandom_range(1)));
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] frm);
        int w;
        bit acc;
        cfg_valid_i = 1'b1; cfg_pattern_i = pat; cfg_len_i = len; cfg_frame_i = frm;
        w = 0;
        do begin
            acc = cfg_ready_o;
            @(posedge clk); #1;
            w++;
        end while (!acc && w < 400);
        cfg_valid_i = 1'b0;
        checks++;
        if (!acc) begin errors++; $display("FAIL cfg_timeout ready never seen after %0d cycles", w); end
        checks++;
        if (busy_o !== 1'b1 || cfg_ready_o !== 1'b0 || count_o !== 8'd0 || det_o !== 1'b0) begin
            errors++;
            $display("FAIL cfg_accept busy=%b ready=%b count=%0d det=%b exp busy=1 ready=0 count=0 det=0",
                     busy_o, cfg_ready_o, count_o, det_o);
        end
    endtask

    // Feeds stim[] for one frame; hole_mode 0=none 1=alternate 2=random.
    // abort_at = number of bits sampled before the abort cycle (-1 = never).
    task automatic run_frame(input logic [7:0] pat, input logic [3:0] len_raw, input logic [7:0] frm,
                             input int hole_mode, input int abort_at);
        int lenE, idx, cyc, exp_cnt, n, nbits;
        bit hist[$];
        bit hole, m, last;
        lenE  = (len_raw == 4'd0) ? 1 : ((len_raw > 4'd8) ? 8 : int'(len_raw));
        nbits = int'(frm) + 1;
        idx = 0; cyc = 0; exp_cnt = 0;
        det_idx.delete();
        while (1) begin
            if (cyc > 3000) begin
                checks++; errors++;
                $display("FAIL frame_timeout bits=%0d of %0d", idx, nbits);
                last_cnt = exp_cnt;
                return;
            end
            if (idx == abort_at) begin
                abort_i   = 1'b1;
                x_valid_i = (idx == nbits - 1) ? 1'b1 : 1'($urandom_range(1));
                x_i       = stim[idx];
                @(posedge clk); #1;
                abort_i = 1'b0; x_valid_i = 1'b0;
                checks++;
                if (done_o !== 1'b0 || det_o !== 1'b0 || busy_o !== 1'b0 || cfg_ready_o !== 1'b1
                    || count_o !== 8'(exp_cnt)) begin
                    errors++;
                    $display("FAIL abort_exit done=%b det=%b busy=%b ready=%b count=%0d exp 0 0 0 1 %0d",
                             done_o, det_o, busy_o, cfg_ready_o, count_o, exp_cnt);
                end
                @(posedge clk); #1;
                checks++;
                if (done_o !== 1'b0 || count_o !== 8'(exp_cnt)) begin
                    errors++;
                    $display("FAIL abort_hold done=%b count=%0d exp done=0 count=%0d", done_o, count_o, exp_cnt);
                end
                last_cnt = exp_cnt;
                return;
            end
            hole = (hole_mode == 1) ? (cyc % 2 == 1) :
                   (hole_mode == 2) ? ($urandom_range(99) < 30) : 1'b0;
            cyc++;
            if (hole) begin
                x_valid_i = 1'b0; x_i = 1'($urandom_range(1));
                @(posedge clk); #1;
                checks++;
                if (det_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b1 || count_o !== 8'(exp_cnt)) begin
                    errors++;
                    $display("FAIL hole det=%b done=%b busy=%b count=%0d exp 0 0 1 %0d",
                             det_o, done_o, busy_o, count_o, exp_cnt);
                end
            end else begin
                x_valid_i = 1'b1; x_i = stim[idx];
                @(posedge clk); #1;
                x_valid_i = 1'b0;
                hist.push_back(stim[idx]);
                idx++;
                n = hist.size();
                m = (n >= lenE);
                if (m) begin
                    for (int k = 0; k < lenE; k++) if (hist[n-1-k] != pat[k]) m = 1'b0;
                end
                if (m) begin
                    det_idx.push_back(idx);
                    if (exp_cnt < 255) exp_cnt++;
                end
                last = (idx == nbits);
                checks++;
                if (det_o !== m) begin
                    errors++;
                    $display("FAIL det bit=%0d got=%b exp=%b", idx, det_o, m);
                end
                checks++;
                if (count_o !== 8'(exp_cnt)) begin
                    errors++;
                    $display("FAIL count bit=%0d got=%0d exp=%0d", idx, count_o, exp_cnt);
                end
                checks++;
                if (done_o !== last || busy_o !== !last || cfg_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_state bit=%0d done=%b busy=%b ready=%b exp done=%b busy=%b ready=0",
                             idx, done_o, busy_o, cfg_ready_o, last, !last);
                end
                if (last) begin
                    @(posedge clk); #1;
                    checks++;
                    if (done_o !== 1'b0 || cfg_ready_o !== 1'b1 || det_o !== 1'b0 || count_o !== 8'(exp_cnt)) begin
                        errors++;
                        $display("FAIL after_done done=%b ready=%b det=%b count=%0d exp 0 1 0 %0d",
                                 done_o, cfg_ready_o, det_o, count_o, exp_cnt);
                    end
                    last_cnt = exp_cnt;
                    return;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (det_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || count_o !== 8'd0 || cfg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_values det=%b done=%b busy=%b count=%0d ready=%b exp 0 0 0 0 1",
                     det_o, done_o, busy_o, count_o, cfg_ready_o);
        end
        #3 reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cfg_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release ready=%b busy=%b exp 1 0", cfg_ready_o, busy_o);
        end
    endtask

    task automatic test_pattern110();
        int exp_det[6] = '{4, 7, 10, 14, 17, 20};
        set_stim_str("1110110110111011011011");
        do_cfg(8'b110, 4'd3, 8'd21);
        run_frame(8'b110, 4'd3, 8'd21, 0, -1);
        checks++;
        if (det_idx.size() != 6) begin
            errors++;
            $display("FAIL p110_num_det got=%0d exp=6", det_idx.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (det_idx[i] != exp_det[i]) begin
                    errors++;
                    $display("FAIL p110_det_pos idx=%0d got=%0d exp=%0d", i, det_idx[i], exp_det[i]);
                end
            end
        end
        checks++;
        if (count_o !== 8'd6) begin errors++; $display("FAIL p110_count got=%0d exp=6", count_o); end
    endtask

    task automatic test_holes();
        set_stim_const(10, 1'b1);
        do_cfg(8'b11, 4'd2, 8'd9);
        run_frame(8'b11, 4'd2, 8'd9, 1, -1);
        checks++;
        if (det_idx.size() != 9 || count_o !== 8'd9) begin
            errors++;
            $display("FAIL holes_total det=%0d count=%0d exp 9 9", det_idx.size(), count_o);
        end
    endtask

    task automatic test_saturation();
        set_stim_const(256, 1'b1);
        do_cfg(8'd1, 4'd0, 8'd255);
        run_frame(8'd1, 4'd0, 8'd255, 0, -1);
        checks++;
        if (det_idx.size() != 256 || count_o !== 8'd255) begin
            errors++;
            $display("FAIL saturation det=%0d count=%0d exp 256 255", det_idx.size(), count_o);
        end
    endtask

    task automatic test_abort();
        set_stim_str("1110110110111011011011");
        do_cfg(8'b110, 4'd3, 8'd21);
        run_frame(8'b110, 4'd3, 8'd21, 0, 8);
        checks++;
        if (count_o !== 8'd2) begin errors++; $display("FAIL abort_count got=%0d exp=2", count_o); end
        set_stim_const(4, 1'b1);
        do_cfg(8'b11, 4'd2, 8'd3);
        run_frame(8'b11, 4'd2, 8'd3, 0, -1);
        // Abort on the last bit: abort must win over done.
        set_stim_str("0110");
        do_cfg(8'b110, 4'd3, 8'd3);
        run_frame(8'b110, 4'd3, 8'd3, 0, 3);
    endtask

    task automatic test_async_reset();
        set_stim_str("11011");
        do_cfg(8'b110, 4'd3, 8'd21);
        for (int i = 0; i < 5; i++) begin
            x_valid_i = 1'b1; x_i = stim[i];
            @(posedge clk); #1;
        end
        x_valid_i = 1'b0;
        checks++;
        if (count_o !== 8'd1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset count=%0d busy=%b exp 1 1", count_o, busy_o);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (det_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || count_o !== 8'd0 || cfg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL async_reset det=%b done=%b busy=%b count=%0d ready=%b exp 0 0 0 0 1",
                     det_o, done_o, busy_o, count_o, cfg_ready_o);
        end
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_busy_cfg();
        set_stim_str("11011010");
        do_cfg(8'b110, 4'd3, 8'd7);
        cfg_valid_i = 1'b1; cfg_pattern_i = 8'b11; cfg_len_i = 4'd2; cfg_frame_i = 8'd4;
        run_frame(8'b110, 4'd3, 8'd7, 2, -1);
        set_stim_const(5, 1'b1);
        do_cfg(8'b11, 4'd2, 8'd4);
        run_frame(8'b11, 4'd2, 8'd4, 0, -1);
        checks++;
        if (count_o !== 8'd4) begin errors++; $display("FAIL busy_cfg_count got=%0d exp=4", count_o); end
    endtask

    task automatic test_single_bit();
        set_stim_const(1, 1'b1);
        do_cfg(8'd1, 4'd1, 8'd0);
        run_frame(8'd1, 4'd1, 8'd0, 0, -1);
    endtask

    task automatic test_random();
        logic [7:0] pat;
        logic [3:0] len;
        logic [7:0] frm;
        int ab;
        for (int it = 0; it < 12; it++) begin
            pat = 8'($urandom);
            len = 4'($urandom_range(0, 15));
            frm = 8'($urandom_range(0, 60));
            ab  = ($urandom_range(3) == 0) ? int'($urandom_range(0, int'(frm))) : -1;
            set_stim_rand(int'(frm) + 1);
            do_cfg(pat, len, frm);
            run_frame(pat, len, frm, 2, ab);
        end
    endtask

    initial begin
        reset = 1'b1; cfg_valid_i = 1'b0; cfg_pattern_i = '0; cfg_len_i = '0; cfg_frame_i = '0;
        abort_i = 1'b0; x_valid_i = 1'b0; x_i = 1'b0; last_cnt = 0;
        test_reset();
        test_pattern110();
        test_holes();
        test_saturation();
        test_abort();
        test_async_reset();
        test_busy_cfg();
        test_single_bit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
